// File: rtl/mux_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the shared mux.
// The arbiter takes the slave side; requesters and mux take the master side.
interface mux_arbiter_if #(
  parameter int N     = 2,
  parameter int SEL_W = 1
);
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] sel;
  logic             valid;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  valid
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output valid
  );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin arbiter driving the select of a shared N:1 mux.
// Grants are registered; each grant is capped at MAX_BURST under contention.
module mux_arbiter #(
  parameter int N         = 2,
  parameter int SEL_W     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q;
  logic [N-1:0]     gnt_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] last_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic [N-1:0]     cand_d;
  logic [SEL_W:0]   idx_d;
  logic [SEL_W-1:0] win_d;
  logic             found_d;
  logic             own_d;
  logic             sat_d;
  logic             take_d;
  logic             drop_d;

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;

  // Scan candidates from last+1 with wrap; the owner is masked out.
  always_comb begin
    cand_d  = bus.req & ~gnt_q;
    own_d   = |(bus.req & gnt_q);
    sat_d   = (cnt_q == CNT_W'(MAX_BURST));
    found_d = 1'b0;
    win_d   = '0;
    idx_d   = '0;
    for (int k = 1; k <= N; k++) begin
      idx_d = {1'b0, last_q} + (SEL_W+1)'(k);
      if (idx_d >= (SEL_W+1)'(N))
        idx_d = idx_d - (SEL_W+1)'(N);
      if (!found_d && cand_d[idx_d[SEL_W-1:0]]) begin
        found_d = 1'b1;
        win_d   = idx_d[SEL_W-1:0];
      end
    end
  end

  // Decide between a new grant, going idle, or keeping the owner.
  always_comb begin
    take_d = 1'b0;
    drop_d = 1'b0;
    unique case (state_q)
      IDLE: take_d = found_d;
      BUSY: begin
        if (!own_d) begin
          take_d = found_d;
          drop_d = !found_d;
        end else if (sat_d) begin
          take_d = found_d;
        end
      end
      default: ;
    endcase
  end

  // Arbiter state and registered grant/select outputs; sel holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(N - 1);
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (take_d) begin
      state_q <= BUSY;
      gnt_q   <= {{(N-1){1'b0}}, 1'b1} << win_d;
      sel_q   <= win_d;
      last_q  <= win_d;
      valid_q <= 1'b1;
      cnt_q   <= CNT_W'(1);
    end else if (drop_d) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (state_q == BUSY && !sat_d) begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed checks of mux_arbiter: N=2 vector table, N=4 reset/rotation,
// and an N=3 single-cycle-burst rotation.
module tb_mux_arbiter;

  logic clk;
  logic rst_n;

  int n_chk  = 0;
  int n_fail = 0;

  mux_arbiter_if #(.N(2), .SEL_W(1)) if2 ();
  mux_arbiter_if #(.N(4), .SEL_W(2)) if4 ();
  mux_arbiter_if #(.N(3), .SEL_W(2)) if3 ();

  mux_arbiter #(.N(2), .SEL_W(1), .MAX_BURST(4)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.slave)
  );

  mux_arbiter #(.N(4), .SEL_W(2), .MAX_BURST(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  mux_arbiter #(.N(3), .SEL_W(2), .MAX_BURST(1)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       sel;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic [1:0] q,
                     input logic [1:0] g, input logic s);
    vec_t v;
    v.rst = r;
    v.req = q;
    v.gnt = g;
    v.sel = s;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [3:0] e4 [9];
  logic [1:0] s4 [9];
  logic [2:0] e3 [4];

  initial begin
    rst_n   = 1'b0;
    if2.req = '0;
    if4.req = '0;
    if3.req = '0;

    // reset held with both requesting
    for (int i = 0; i < 3; i++) add(1'b0, 2'b11, 2'b00, 1'b0);
    // single request then drop
    add(1'b1, 2'b01, 2'b01, 1'b0);
    add(1'b1, 2'b00, 2'b00, 1'b0);
    // re-reset, then contention: 4 x 0, 4 x 1, 4 x 0
    add(1'b0, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b1, 2'b11, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b1, 2'b11, 2'b10, 1'b1);
    for (int i = 0; i < 4; i++) add(1'b1, 2'b11, 2'b01, 1'b0);
    // lone requester 1: handoff, then saturates with no release
    for (int i = 0; i < 10; i++) add(1'b1, 2'b10, 2'b10, 1'b1);
    // idle keeps sel=1, then owner 0 reaches cnt=2 and drops
    add(1'b1, 2'b00, 2'b00, 1'b1);
    add(1'b1, 2'b01, 2'b01, 1'b0);
    add(1'b1, 2'b01, 2'b01, 1'b0);
    add(1'b1, 2'b10, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b1, 2'b11, 2'b10, 1'b1);
    add(1'b1, 2'b11, 2'b01, 1'b0);

    foreach (vt[i]) begin
      @(negedge clk);
      rst_n   = vt[i].rst;
      if2.req = vt[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d gnt", i), 32'(if2.gnt), 32'(vt[i].gnt));
      chk($sformatf("v%0d sel", i), 32'(if2.sel), 32'(vt[i].sel));
      chk($sformatf("v%0d valid", i), 32'(if2.valid), 32'(|vt[i].gnt));
      chk($sformatf("v%0d onehot", i), 32'($onehot0(if2.gnt)), 32'd1);
    end

    // async reset mid-burst on N=2
    @(negedge clk);
    if2.req = 2'b10;
    @(posedge clk);
    #1;
    chk("n2 pre-rst gnt", 32'(if2.gnt), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("n2 async gnt", 32'(if2.gnt), 32'h0);
    chk("n2 async valid", 32'(if2.valid), 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    if2.req = 2'b11;
    @(posedge clk);
    #1;
    chk("n2 post-rst gnt", 32'(if2.gnt), 32'h1);
    chk("n2 post-rst sel", 32'(if2.sel), 32'h0);
    @(negedge clk);
    if2.req = 2'b00;

    // N=4: grant 3, reset mid-cycle, then req=1010 gives 1,3,1
    @(negedge clk);
    if4.req = 4'b1000;
    @(posedge clk);
    #1;
    chk("n4 pre-rst gnt", 32'(if4.gnt), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("n4 async gnt", 32'(if4.gnt), 32'h0);
    chk("n4 async valid", 32'(if4.valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      e4[i]   = 4'b0010; s4[i]   = 2'd1;
      e4[i+4] = 4'b1000; s4[i+4] = 2'd3;
    end
    e4[8] = 4'b0010;
    s4[8] = 2'd1;
    @(negedge clk);
    rst_n   = 1'b1;
    if4.req = 4'b1010;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("n4 c%0d gnt", i), 32'(if4.gnt), 32'(e4[i]));
      chk($sformatf("n4 c%0d sel", i), 32'(if4.sel), 32'(s4[i]));
    end
    @(negedge clk);
    if4.req = '0;

    // N=3, MAX_BURST=1: all requesting rotates every cycle
    e3[0] = 3'b001;
    e3[1] = 3'b010;
    e3[2] = 3'b100;
    e3[3] = 3'b001;
    @(negedge clk);
    if3.req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("n3 c%0d gnt", i), 32'(if3.gnt), 32'(e3[i]));
      chk($sformatf("n3 c%0d sel", i), 32'(if3.sel), i % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
